// File: rtl/mig_ui_responder.sv
// mig_ui_responder: MIG-style UI slave model with a single command slot, write-data FIFO and fixed-latency reads.
// Optional random backpressure on app_rdy/app_wdf_rdy is enabled by defining MIG_RESP_BACKPRESSURE_EN.
module mig_ui_responder #(
   parameter int MEM_WORDS_LOG2 = 6,
   parameter int RD_LATENCY     = 4,
   parameter int CALIB_CYCLES   = 16,
   parameter int WDF_DEPTH      = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   output logic         calib_done,
   input  logic         app_en,
   input  logic [2:0]   app_cmd,
   input  logic [29:0]  app_addr,
   output logic         app_rdy,
   input  logic         app_wdf_wren,
   input  logic [255:0] app_wdf_data,
   input  logic         app_wdf_end,
   input  logic [31:0]  app_wdf_mask,
   output logic         app_wdf_rdy,
   output logic [255:0] app_rd_data,
   output logic         app_rd_data_valid,
   output logic         app_rd_data_end,
   output logic         cmd_err
);
   localparam int PW = $clog2(WDF_DEPTH);
   localparam int CW = $clog2(CALIB_CYCLES + 1);
   localparam int PL = RD_LATENCY - 1;
   typedef enum logic [1:0] {CALIB, IDLE, WR_WAIT, RD_ISSUE} state_t;
   state_t                    state;
   logic [CW-1:0]             cal_cnt;
   logic [MEM_WORDS_LOG2-1:0] cmd_idx;
   logic [255:0]              mem [2**MEM_WORDS_LOG2];
   logic [255:0]              fifo_d [WDF_DEPTH];
   logic [31:0]               fifo_m [WDF_DEPTH];
   logic [PW-1:0]             wp, rp;
   logic [PW:0]               cnt;
   logic [255:0]              pd [PL];
   logic [PL-1:0]             pv;
   logic                      rdy_ok, wdf_ok, acc, push, pop;
   logic                      unused_addr;
   assign unused_addr = ^{app_addr[29:MEM_WORDS_LOG2+3], app_addr[2:0]};
`ifdef MIG_RESP_BACKPRESSURE_EN
   logic [7:0] lfsr;
   // Backpressure LFSR, frozen until calibration completes
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) lfsr <= 8'hA5;
      else if (calib_done) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign rdy_ok = lfsr[1:0] != 2'b00;
   assign wdf_ok = lfsr[3:2] != 2'b00;
`else
   assign rdy_ok = 1'b1;
   assign wdf_ok = 1'b1;
`endif
   assign app_rdy     = state == IDLE && rdy_ok;
   assign app_wdf_rdy = calib_done && cnt != WDF_DEPTH[PW:0] && wdf_ok;
   assign acc         = app_en && app_rdy;
   assign push        = app_wdf_wren && app_wdf_rdy;
   assign pop         = state == WR_WAIT && cnt != '0;
   // Control FSM: calibration wait, command capture, error pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CALIB;
         cal_cnt    <= '0;
         calib_done <= 1'b0;
         cmd_idx    <= '0;
         cmd_err    <= 1'b0;
      end else begin
         cmd_err <= (acc && app_cmd[2:1] != 2'b00) || (app_wdf_wren != app_wdf_end);
         case (state)
            CALIB:
               if (cal_cnt == CW'(CALIB_CYCLES - 1)) begin
                  state      <= IDLE;
                  calib_done <= 1'b1;
               end else cal_cnt <= cal_cnt + 1'b1;
            IDLE:
               if (acc) begin
                  cmd_idx <= app_addr[MEM_WORDS_LOG2+2:3];
                  state   <= app_cmd == 3'b000 ? WR_WAIT : app_cmd == 3'b001 ? RD_ISSUE : IDLE;
               end
            WR_WAIT: if (pop) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   // Write-data FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   // FIFO entry storage, not reset
   always_ff @(posedge clk)
      if (push) begin
         fifo_d[wp] <= app_wdf_data;
         fifo_m[wp] <= app_wdf_mask;
      end
   // Storage array byte-masked write on FIFO pop; contents survive reset
   always_ff @(posedge clk)
      if (pop)
         for (int i = 0; i < 32; i++)
            if (!fifo_m[rp][i]) mem[cmd_idx][8*i +: 8] <= fifo_d[rp][8*i +: 8];
   // Read pipeline and output register; data holds between valid pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv                <= '0;
         for (int i = 0; i < PL; i++) pd[i] <= '0;
         app_rd_data       <= '0;
         app_rd_data_valid <= 1'b0;
         app_rd_data_end   <= 1'b0;
      end else begin
         pv[0] <= state == RD_ISSUE;
         pd[0] <= mem[cmd_idx];
         for (int i = 1; i < PL; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         app_rd_data_valid <= pv[PL-1];
         app_rd_data_end   <= pv[PL-1];
         if (pv[PL-1]) app_rd_data <= pd[PL-1];
      end
   end
endmodule

// File: tb/tb_mig_ui_responder.sv
// tb_mig_ui_responder: directed self-checking bench for mig_ui_responder (default build).
module tb_mig_ui_responder;
   logic         clk = 1'b0;
   logic         reset_n;
   logic         calib_done;
   logic         app_en;
   logic [2:0]   app_cmd;
   logic [29:0]  app_addr;
   logic         app_rdy;
   logic         app_wdf_wren;
   logic [255:0] app_wdf_data;
   logic         app_wdf_end;
   logic [31:0]  app_wdf_mask;
   logic         app_wdf_rdy;
   logic [255:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         app_rd_data_end;
   logic         cmd_err;
   int           vectors = 0;
   int           miscompares = 0;
   logic [255:0] a5 = {32{8'hA5}};
   logic [255:0] dd = {8{32'h1234_5678}};

   mig_ui_responder dut (
      .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
      .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_rd_data_end(app_rd_data_end), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [255:0] d, input logic [31:0] m);
      int n = 0;
      while (!app_wdf_rdy && n < 50) begin tick; n++; end
      chk("push_rdy", app_wdf_rdy, 1);
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
      tick;
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
   endtask

   task automatic cmd(input logic [2:0] c, input logic [29:0] a);
      int n = 0;
      while (!app_rdy && n < 50) begin tick; n++; end
      chk("cmd_rdy", app_rdy, 1);
      app_en = 1'b1; app_cmd = c; app_addr = a;
      tick;
      app_en = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [29:0] a, input logic [255:0] exp);
      cmd(3'b001, a);
      for (int i = 0; i < 3; i++) begin tick; chk({tag, "_early_valid"}, app_rd_data_valid, 0); end
      tick;
      chk({tag, "_valid"}, app_rd_data_valid, 1);
      chk({tag, "_end"}, app_rd_data_end, 1);
      chk({tag, "_data"}, app_rd_data, exp);
      tick;
      chk({tag, "_valid_drop"}, app_rd_data_valid, 0);
      chk({tag, "_hold"}, app_rd_data, exp);
   endtask

   initial begin
      reset_n = 1'b0; app_en = 1'b0; app_cmd = '0; app_addr = '0;
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
      repeat (3) tick;
      chk("rst_calib_done", calib_done, 0);
      chk("rst_app_rdy", app_rdy, 0);
      chk("rst_wdf_rdy", app_wdf_rdy, 0);
      chk("rst_valid", app_rd_data_valid, 0);
      chk("rst_rd_data", app_rd_data, 0);
      chk("rst_cmd_err", cmd_err, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick;
         chk("calib_wait_done", calib_done, 0);
         chk("calib_wait_rdy", app_rdy, 0);
         chk("calib_wait_wdf", app_wdf_rdy, 0);
      end
      tick;
      chk("calib_done", calib_done, 1);
      chk("calib_app_rdy", app_rdy, 1);
      chk("calib_wdf_rdy", app_wdf_rdy, 1);

      push(a5, '0);
      cmd(3'b000, 30'd0);
      rd("rd_a5", 30'd0, a5);

      push('1, '0);
      cmd(3'b000, 30'd8);
      cmd(3'b000, 30'd8);
      push('0, 32'hFFFF_FFFE);
      rd("rd_mask", 30'd8, {{248{1'b1}}, 8'h00});

      for (int i = 0; i < 4; i++) push({8{32'hC0DE_0000 | i}}, '0);
      chk("fifo_full_rdy", app_wdf_rdy, 0);
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = '1;
      tick;
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
      chk("full_push_no_err", cmd_err, 0);
      chk("full_push_ignored", app_wdf_rdy, 0);
      cmd(3'b000, 30'd0);
      tick;
      chk("fifo_pop_rdy", app_wdf_rdy, 1);
      cmd(3'b000, 30'd8);
      cmd(3'b000, 30'd16);
      cmd(3'b000, 30'd24);
      rd("rd_beat0", 30'd0, {8{32'hC0DE_0000}});
      rd("rd_beat1", 30'd8, {8{32'hC0DE_0001}});
      rd("rd_beat2", 30'd16, {8{32'hC0DE_0002}});
      rd("rd_beat3", 30'd24, {8{32'hC0DE_0003}});

      cmd(3'b000, 30'd512);
      push(dd, '0);
      rd("rd_alias", 30'd0, dd);
      rd("rd_low_bits", 30'd7, dd);
      cmd(3'b111, 30'd0);
      chk("illegal_err", cmd_err, 1);
      chk("illegal_idle", app_rdy, 1);
      tick;
      chk("illegal_err_drop", cmd_err, 0);
      app_wdf_end = 1'b1;
      tick;
      app_wdf_end = 1'b0;
      chk("mismatch_err", cmd_err, 1);
      tick;
      chk("mismatch_err_drop", cmd_err, 0);
      rd("rd_after_illegal", 30'd0, dd);

      cmd(3'b001, 30'd0);
      repeat (2) tick;
      reset_n = 1'b0;
      #1;
      chk("midrd_rst_valid", app_rd_data_valid, 0);
      chk("midrd_rst_data", app_rd_data, 0);
      chk("midrd_rst_calib", calib_done, 0);
      for (int i = 0; i < 4; i++) begin tick; chk("midrd_no_valid", app_rd_data_valid, 0); end
      reset_n = 1'b1;
      repeat (15) tick;
      chk("recal_wait", calib_done, 0);
      chk("recal_no_valid", app_rd_data_valid, 0);
      tick;
      chk("recal_done", calib_done, 1);
      rd("rd_survive", 30'd0, dd);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
